// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - segmented, pipelined two's-complement adder/subtractor
// One SEG-bit segment resolved per stage; carry and skewed operands ride the pipeline.
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of SEG");
  end

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic [SEG:0]     seg_sum [STAGES];

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             en;

  // Subtraction folds into the operands here; nothing downstream knows the mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  assign out_valid = v_q[LAST] & ~rst;
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;

  assign seg_sum[0] = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + (SEG+1)'(c_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q[0] <= 1'b0;
      a_q[0] <= '0;
      b_q[0] <= '0;
      s_q[0] <= '0;
      c_q[0] <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b_eff;
      s_q[0] <= WIDTH'(seg_sum[0][SEG-1:0]);
      c_q[0] <= seg_sum[0][SEG];
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] s_next;

    assign seg_sum[k] = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                      + (SEG+1)'(c_q[k-1]);

    always_comb begin
      s_next = s_q[k-1];
      s_next[k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else if (en) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_next;
        c_q[k] <= seg_sum[k][SEG];
      end
    end
  end

  // Carry into the MSB is recovered as a^b^sum at that bit, avoiding an extra register.
  assign sum  = rst ? '0 : s_q[LAST];
  assign cout = ~rst & c_q[LAST];
  assign ovf  = ~rst & (c_q[LAST] ^ a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - directed and randomised checks for pipelined_add_sub
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        s8_in_valid, s8_in_ready, s8_cin, s8_sub, s8_out_valid, s8_out_ready, s8_cout, s8_ovf;
  logic [7:0]  s8_a, s8_b, s8_sum;

  logic        s32_in_valid, s32_in_ready, s32_cin, s32_sub, s32_out_valid, s32_out_ready, s32_cout, s32_ovf;
  logic [31:0] s32_a, s32_b, s32_sum;

  int checks = 0;
  int errors = 0;

  pipelined_add_sub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  pipelined_add_sub #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .a(s8_a), .b(s8_b),
    .cin(s8_cin), .sub(s8_sub), .out_valid(s8_out_valid), .out_ready(s8_out_ready), .sum(s8_sum),
    .cout(s8_cout), .ovf(s8_ovf));

  pipelined_add_sub #(.WIDTH(32), .SEG(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s32_in_valid), .in_ready(s32_in_ready), .a(s32_a), .b(s32_b),
    .cin(s32_cin), .sub(s32_sub), .out_valid(s32_out_valid), .out_ready(s32_out_ready), .sum(s32_sum),
    .cout(s32_cout), .ovf(s32_ovf));

  // Reference: {ovf, cout, sum} with sum zero-extended to 32 bits.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
    logic [63:0] mask, xx, yy, full;
    logic [33:0] r;
    mask = (64'd1 << w) - 64'd1;
    xx   = {32'h0, x} & mask;
    yy   = (sb ? ~{32'h0, y} : {32'h0, y}) & mask;
    full = xx + yy + ((sb | ci) ? 64'd1 : 64'd0);
    r[31:0] = 32'(full & mask);
    r[32]   = full[w];
    r[33]   = (xx[w-1] == yy[w-1]) && (full[w-1] != xx[w-1]);
    return r;
  endfunction

  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                          output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if ({s8_out_valid, s32_out_valid} !== 2'b00) begin errors++; $display("FAIL reset_sweep_valid: got %b expected 00", {s8_out_valid, s32_out_valid}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    logic [15:0] s; logic c, o; int lat;
    run_beat(16'h1234, 16'h1111, 1'b0, 1'b0, s, c, o, lat);
    checks++; if (s !== 16'h2345) begin errors++; $display("FAIL add_sum: got %h expected 2345", s); end
    checks++; if ({c, o} !== 2'b00) begin errors++; $display("FAIL add_cout_ovf: got %b expected 00", {c, o}); end
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_carry;
    logic [15:0] s; logic c, o; int lat;
    run_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c, o, lat);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL carry_all_sum: got %h expected 0000", s); end
    checks++; if ({c, o} !== 2'b10) begin errors++; $display("FAIL carry_all_cout_ovf: got %b expected 10", {c, o}); end
    run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    checks++; if (s !== 16'h8000) begin errors++; $display("FAIL carry_ovf_sum: got %h expected 8000", s); end
    checks++; if ({c, o} !== 2'b01) begin errors++; $display("FAIL carry_ovf_cout_ovf: got %b expected 01", {c, o}); end
  endtask

  task automatic test_subtract;
    logic [15:0] s; logic c, o; int lat;
    run_beat(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat);
    checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum: got %h expected fffe", s); end
    checks++; if ({c, o} !== 2'b00) begin errors++; $display("FAIL sub_borrow_cout_ovf: got %b expected 00", {c, o}); end
    run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
    checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_sum: got %h expected 7fff", s); end
    checks++; if ({c, o} !== 2'b11) begin errors++; $display("FAIL sub_ovf_cout_ovf: got %b expected 11", {c, o}); end
  endtask

  task automatic test_backpressure;
    int nxt = 0, got = 0;
    logic stalled_prev = 1'b0;
    logic [15:0] held = '0;
    for (int t = 0; t < 40 && got < 8; t++) begin
      out_ready = !(t >= 5 && t <= 7);
      in_valid  = (nxt < 8);
      a = 16'(nxt); b = 16'(nxt); cin = 1'b0; sub = 1'b0;
      #1;
      if (stalled_prev) begin
        checks++; if (sum !== held) begin errors++; $display("FAIL bp_hold t=%0d: got %h expected %h", t, sum, held); end
      end
      stalled_prev = out_valid && !out_ready;
      if (stalled_prev) begin
        held = sum;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready t=%0d: got %b expected 0", t, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++; if (sum !== 16'(2 * got)) begin errors++; $display("FAIL bp_order: got %h expected %h", sum, 16'(2 * got)); end
        got++;
      end
      if (in_valid && in_ready) nxt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0010; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready_during: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0) begin errors++; $display("FAIL rstmid_sum: got %h expected 0000", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale beats expected 0", seen); end
  endtask

  task automatic test_sweep;
    logic [33:0] q8[$], q32[$];
    int q8_cyc[$], q8_stl[$], q32_cyc[$], q32_stl[$];
    int cyc = 0, stl8 = 0, stl32 = 0, acc8 = 0, acc32 = 0;
    logic [33:0] e; int ca, sa;
    logic done = 1'b0;
    for (int n = 0; n < 20000 && !done; n++) begin
      s8_in_valid  = (acc8 < 1000) && ($urandom_range(0, 9) < 7);
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom); s8_sub = 1'($urandom);
      s8_out_ready = ($urandom_range(0, 9) < 7);
      s32_in_valid = (acc32 < 1000) && ($urandom_range(0, 9) < 7);
      s32_a = $urandom; s32_b = $urandom; s32_cin = 1'($urandom); s32_sub = 1'($urandom);
      s32_out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (s8_out_valid && s8_out_ready) begin
        checks++;
        if (q8.size() == 0) begin errors++; $display("FAIL sweep8_spurious: got out_valid expected none"); end
        else begin
          e = q8.pop_front(); ca = q8_cyc.pop_front(); sa = q8_stl.pop_front();
          if ({s8_ovf, s8_cout, 24'h0, s8_sum} !== e) begin errors++; $display("FAIL sweep8_result: got %h expected %h", {s8_ovf, s8_cout, 24'h0, s8_sum}, e); end
          checks++;
          if (cyc != ca + 1 + (stl8 - sa)) begin errors++; $display("FAIL sweep8_latency: got %0d expected %0d", cyc - ca, 1 + stl8 - sa); end
        end
      end
      if (s8_in_valid && s8_in_ready) begin
        q8.push_back(ref_op(8, {24'h0, s8_a}, {24'h0, s8_b}, s8_cin, s8_sub)); q8_cyc.push_back(cyc); q8_stl.push_back(stl8); acc8++;
      end
      if (s8_out_valid && !s8_out_ready) stl8++;
      if (s32_out_valid && s32_out_ready) begin
        checks++;
        if (q32.size() == 0) begin errors++; $display("FAIL sweep32_spurious: got out_valid expected none"); end
        else begin
          e = q32.pop_front(); ca = q32_cyc.pop_front(); sa = q32_stl.pop_front();
          if ({s32_ovf, s32_cout, s32_sum} !== e) begin errors++; $display("FAIL sweep32_result: got %h expected %h", {s32_ovf, s32_cout, s32_sum}, e); end
          checks++;
          if (cyc != ca + 8 + (stl32 - sa)) begin errors++; $display("FAIL sweep32_latency: got %0d expected %0d", cyc - ca, 8 + stl32 - sa); end
        end
      end
      if (s32_in_valid && s32_in_ready) begin
        q32.push_back(ref_op(32, s32_a, s32_b, s32_cin, s32_sub)); q32_cyc.push_back(cyc); q32_stl.push_back(stl32); acc32++;
      end
      if (s32_out_valid && !s32_out_ready) stl32++;
      cyc++;
      done = (acc8 >= 1000) && (acc32 >= 1000) && (q8.size() == 0) && (q32.size() == 0);
      @(posedge clk); #1;
    end
    s8_in_valid = 1'b0; s32_in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL sweep_timeout: got acc8=%0d acc32=%0d pending=%0d/%0d expected all drained", acc8, acc32, q8.size(), q32.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s8_in_valid = 1'b0; s8_out_ready = 1'b1; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_sub = 1'b0;
    s32_in_valid = 1'b0; s32_out_ready = 1'b1; s32_a = '0; s32_b = '0; s32_cin = 1'b0; s32_sub = 1'b0;
    test_reset;
    test_basic_add;
    test_carry;
    test_subtract;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
